// File: rtl/map_pixel_fetcher.sv
// map_pixel_fetcher: turns display pixel coordinates into world-map tile reads
// and presents the 2-bit tile value aligned with the delayed coordinates.
// A RAM read is issued only when the tile address changes; blanking forces a
// re-fetch so that map writes made during blanking become visible.
module map_pixel_fetcher #(
  parameter int TILE_SHIFT = 3,
  parameter int MAP_LOG2   = 7,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  video_on,
  input  logic [11:0]           pixel_row,
  input  logic [11:0]           pixel_column,
  output logic [2*MAP_LOG2-1:0] map_addr,
  output logic                  map_rd_en,
  input  logic [1:0]            map_rd_data,
  output logic [1:0]            map_value,
  output logic [11:0]           pixel_row_o,
  output logic [11:0]           pixel_column_o,
  output logic                  out_valid,
  output logic [19:0]           fetch_count
);

  localparam int          TILE_W    = 12 - TILE_SHIFT;
  localparam int          ADDR_W    = 2 * MAP_LOG2;
  localparam logic [19:0] COUNT_MAX = '1;
  localparam logic [1:0]  BLACK     = 2'b11;

  logic [TILE_W-1:0] tile_row;
  logic [TILE_W-1:0] tile_col;
  logic              in_range;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              origin;
  logic              last_addr_valid;

  // Delay line, index 0 is the stage-0 register, index RD_LATENCY lines up
  // with map_rd_data.
  logic [RD_LATENCY:0] d_valid;
  logic [RD_LATENCY:0] d_in_range;
  logic [RD_LATENCY:0] d_rd;
  logic [11:0]         d_row [RD_LATENCY+1];
  logic [11:0]         d_col [RD_LATENCY+1];
  logic [1:0]          hold;

  // Tile coordinates; the upper tile bits must be clear for the pixel to be on the map.
  assign tile_row = pixel_row[11:TILE_SHIFT];
  assign tile_col = pixel_column[11:TILE_SHIFT];
  assign in_range = (tile_row[TILE_W-1:MAP_LOG2] == '0) &&
                    (tile_col[TILE_W-1:MAP_LOG2] == '0);
  assign addr     = {tile_row[MAP_LOG2-1:0], tile_col[MAP_LOG2-1:0]};
  // map_addr only ever loads on a read, so it doubles as the last fetched address.
  assign rd       = video_on && in_range && (!last_addr_valid || (addr != map_addr));
  assign origin   = video_on && (pixel_row == 12'd0) && (pixel_column == 12'd0);

  // Stage 0: issue the RAM read and remember which tile it fetched.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from pre-edge values regardless of block ordering.
    if (reset) begin
      map_addr        <= '0;
      map_rd_en       <= 1'b0;
      last_addr_valid <= 1'b0;
    end else begin
      map_rd_en <= rd;
      if (rd) map_addr <= addr;
      if (!video_on)  last_addr_valid <= 1'b0;
      else if (rd)    last_addr_valid <= 1'b1;
    end
  end

  // Control delay line: valid, in_range and rd travel alongside the RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_valid    <= '0;
      d_in_range <= '0;
      d_rd       <= '0;
    end else begin
      d_valid    <= {d_valid[RD_LATENCY-1:0], video_on};
      d_in_range <= {d_in_range[RD_LATENCY-1:0], in_range};
      d_rd       <= {d_rd[RD_LATENCY-1:0], rd};
    end
  end

  // Coordinate delay line.
  always_ff @(posedge clk) begin
    // NOTE: the coordinate pipeline has no reset; its contents are only ever
    // used under the reset-cleared d_valid bits, and the outputs are reset.
    d_row[0] <= pixel_row;
    d_col[0] <= pixel_column;
    for (int i = 1; i <= RD_LATENCY; i++) begin
      d_row[i] <= d_row[i-1];
      d_col[i] <= d_col[i-1];
    end
  end

  // Output stage: pick fresh RAM data, the held tile value, or black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_value      <= BLACK;
      pixel_row_o    <= '0;
      pixel_column_o <= '0;
      out_valid      <= 1'b0;
      hold           <= 2'b00;
    end else begin
      out_valid      <= d_valid[RD_LATENCY];
      pixel_row_o    <= d_row[RD_LATENCY];
      pixel_column_o <= d_col[RD_LATENCY];
      if (!d_valid[RD_LATENCY] || !d_in_range[RD_LATENCY]) begin
        map_value <= BLACK;
      end else if (d_rd[RD_LATENCY]) begin
        map_value <= map_rd_data;
        hold      <= map_rd_data;
      end else begin
        map_value <= hold;
      end
    end
  end

  // Per-frame read counter: restarts at the first active pixel, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (origin) begin
      fetch_count <= rd ? 20'd1 : 20'd0;
    end else if (rd && (fetch_count != COUNT_MAX)) begin
      fetch_count <= fetch_count + 20'd1;
    end
  end

endmodule

// File: tb/tb_map_pixel_fetcher.sv
// Bench for map_pixel_fetcher: two instances (read latency 1 and 3) share the
// same pixel stream; a tile-level reference model predicts every output and a
// per-instance queue lines the predictions up with the DUT output stage.
module tb_map_pixel_fetcher;

  typedef struct {
    int         stamp;
    logic       ov;
    logic [1:0] val;
    logic [11:0] row;
    logic [11:0] col;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        video_on;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;

  logic [13:0] addr1, addr3;
  logic        en1, en3;
  logic [1:0]  data1, data3;
  logic [1:0]  val1, val3;
  logic [11:0] row1, row3, col1, col3;
  logic        ov1, ov3;
  logic [19:0] cnt1, cnt3;

  logic [1:0] mem [16384];
  logic [1:0] rd1_q;
  logic [1:0] rd3_q [3];

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  exp_t q1[$];
  exp_t q3[$];

  // Reference model state
  int         m_last;
  bit         m_lav;
  logic [1:0] m_hold;
  int         m_cnt;

  map_pixel_fetcher #(.TILE_SHIFT(3), .MAP_LOG2(7), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .map_addr(addr1), .map_rd_en(en1), .map_rd_data(data1),
    .map_value(val1), .pixel_row_o(row1), .pixel_column_o(col1),
    .out_valid(ov1), .fetch_count(cnt1)
  );

  map_pixel_fetcher #(.TILE_SHIFT(3), .MAP_LOG2(7), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .map_addr(addr3), .map_rd_en(en3), .map_rd_data(data3),
    .map_value(val3), .pixel_row_o(row3), .pixel_column_o(col3),
    .out_valid(ov3), .fetch_count(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: when the read enable is low the data port shows a corrupted
  // word, so any use of read data on a non-read pixel is visible.
  always @(posedge clk) begin
    rd1_q    <= en1 ? mem[addr1] : ~mem[addr1];
    rd3_q[0] <= en3 ? mem[addr3] : ~mem[addr3];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign data1 = rd1_q;
  assign data3 = rd3_q[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_out(input string who, input exp_t e, input logic ov,
                         input logic [1:0] v, input logic [11:0] r, input logic [11:0] c);
    check({who, "_out_valid"}, ov, e.ov);
    check({who, "_map_value"}, v, e.val);
    check({who, "_row_o"}, r, e.row);
    check({who, "_col_o"}, c, e.col);
  endtask

  // Output scoreboard: an entry stamped s is due after s+L+2 posedges.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (q1.size() > 0 && q1[0].stamp + 3 <= cyc) begin
        e = q1.pop_front();
        check("l1_due", cyc, e.stamp + 3);
        cmp_out("l1", e, ov1, val1, row1, col1);
      end
      if (q3.size() > 0 && q3[0].stamp + 5 <= cyc) begin
        e = q3.pop_front();
        check("l3_due", cyc, e.stamp + 5);
        cmp_out("l3", e, ov3, val3, row3, col3);
      end
    end
  end

  task automatic model_reset();
    m_last = 0;
    m_lav  = 1'b0;
    m_hold = 2'b00;
    m_cnt  = 0;
  endtask

  // Drive one pixel (called at a falling edge), predict, then check stage 0.
  task automatic drive(input logic v, input int r, input int c);
    int   tr, tc, a;
    logic inr, rd;
    exp_t e;
    video_on     = v;
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    tr  = r / 8;
    tc  = c / 8;
    inr = (tr < 128) && (tc < 128);
    a   = (tr % 128) * 128 + (tc % 128);
    rd  = v && inr && (!m_lav || a != m_last);
    e.stamp = cyc;
    e.ov    = v;
    e.row   = 12'(r);
    e.col   = 12'(c);
    if (!v || !inr) begin
      e.val = 2'b11;
    end else begin
      if (rd) m_hold = mem[a];
      e.val = m_hold;
    end
    if (!v) m_lav = 1'b0;
    if (rd) begin
      m_last = a;
      m_lav  = 1'b1;
    end
    if (v && r == 0 && c == 0) m_cnt = rd ? 1 : 0;
    else if (rd && m_cnt < 20'hFFFFF) m_cnt++;
    q1.push_back(e);
    q3.push_back(e);
    @(posedge clk);
    #1;
    check("l1_rd_en", en1, rd);
    check("l3_rd_en", en3, rd);
    check("l1_map_addr", addr1, m_last);
    check("l3_map_addr", addr3, m_last);
    check("l1_fetch_count", cnt1, m_cnt);
    check("l3_fetch_count", cnt3, m_cnt);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_map_addr", addr1, 0);
    check("rst_rd_en", en1, 0);
    check("rst_map_value", val1, 2'b11);
    check("rst_row_o", row1, 0);
    check("rst_col_o", col1, 0);
    check("rst_out_valid", ov1, 0);
    check("rst_fetch_count", cnt1, 0);
    check("rst3_map_value", val3, 2'b11);
    check("rst3_out_valid", ov3, 0);
    check("rst3_fetch_count", cnt3, 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 2'b00;
    mem[0]    = 2'b01;
    mem[1]    = 2'b10;
    mem[1561] = 2'b01;
    model_reset();
    reset        = 1'b1;
    video_on     = 1'b0;
    pixel_row    = '0;
    pixel_column = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    // Tile reuse along row 0: reads only at columns 0 and 8.
    for (int c = 0; c < 16; c++) drive(1'b1, 0, c);

    // Address arithmetic: row 100, column 200 -> tile (12, 25).
    drive(1'b0, 0, 0);
    drive(1'b1, 100, 200);
    check("addr_1561", addr1, 1561);

    // Out of range row: no read, black, still a valid pixel.
    drive(1'b1, 1024, 5);
    drive(1'b1, 100, 1024);

    // Blanking re-fetch: same tile re-read after a one-cycle gap with new RAM data.
    for (int c = 0; c < 4; c++) drive(1'b1, 2, c);
    mem[0] = 2'b10;
    drive(1'b0, 2, 3);
    drive(1'b1, 2, 4);
    drive(1'b1, 2, 5);

    // Asynchronous reset mid-line discards everything in flight.
    for (int c = 0; c < 6; c++) drive(1'b1, 5, c * 8);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values();
    q1.delete();
    q3.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 6, 0);
    drive(1'b0, 6, 0);
    for (int c = 0; c < 4; c++) drive(1'b1, 6, c * 4);

    // Full line from the frame origin: one read per tile, 128 in total.
    drive(1'b0, 0, 0);
    for (int c = 0; c < 1024; c++) drive(1'b1, 0, c);
    check("line_count_l1", cnt1, 128);
    check("line_count_l3", cnt3, 128);

    // Drain both pipelines and make sure every prediction was consumed.
    repeat (6) drive(1'b0, 0, 0);
    repeat (8) @(negedge clk);
    check("l1_queue_empty", q1.size(), 0);
    check("l3_queue_empty", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
